// File: rtl/led_mode_selector.sv
// led_mode_selector
//   Output stage of the heartbeat-light design. It debounces the user
//   push-button. Each accepted press steps to the next mode. Every mode
//   change forces the LEDs off for a short blanking interval. The pattern
//   of the selected mode driver is registered onto the board LEDs.
//
// Ports
//   clk        : system clock (single domain)
//   rst_n      : asynchronous active-low reset
//   key_n      : raw push-button, active low, asynchronous to clk
//   modeN_led  : 8-bit patterns from the per-mode LED drivers (N = 0..3)
//   led_out    : registered LED drive, 1 = on
//   mode       : registered current mode index
//   mode_chg   : one-cycle pulse in the cycle after each accepted press
module led_mode_selector #(
    parameter int NUM_MODES    = 4,
    parameter int DEBOUNCE_CYC = 240000,
    parameter int BLANK_CYC    = 600000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_n,
    input  logic [7:0] mode0_led,
    input  logic [7:0] mode1_led,
    input  logic [7:0] mode2_led,
    input  logic [7:0] mode3_led,
    output logic [7:0] led_out,
    output logic [1:0] mode,
    output logic       mode_chg
);

    localparam logic [23:0] DB_LAST    = 24'(DEBOUNCE_CYC - 1);
    localparam logic [23:0] BLANK_LAST = 24'(BLANK_CYC - 1);
    localparam logic [1:0]  MODE_LAST  = 2'(NUM_MODES - 1);

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizer. It idles high, which is the released level.
    // ------------------------------------------------------------------
    logic key_meta;
    logic key_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= key_n;
            key_sync <= key_meta;
        end
    end

    // ------------------------------------------------------------------
    // Debouncer. A new level is accepted only after DEBOUNCE_CYC
    // consecutive cycles of disagreement with the accepted level. Any
    // return to the accepted level clears the count.
    // ------------------------------------------------------------------
    logic        key_state;
    logic [23:0] db_cnt;
    logic        press_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_state <= 1'b1;
            db_cnt    <= 24'd0;
        end else if (key_sync == key_state) begin
            db_cnt <= 24'd0;
        end else if (db_cnt == DB_LAST) begin
            key_state <= key_sync;
            db_cnt    <= 24'd0;
        end else begin
            db_cnt <= db_cnt + 24'd1;
        end
    end

    // Asserted during the cycle whose closing edge flips key_state from
    // 1 to 0. The debouncer and the FSM both act on that same edge.
    // Releases (0 -> 1) are not events.
    assign press_evt = key_state && !key_sync && (db_cnt == DB_LAST);

    // ------------------------------------------------------------------
    // SHOW / BLANK state machine
    // ------------------------------------------------------------------
    state_t      state;
    state_t      state_nxt;
    logic [23:0] blank_cnt;
    logic [23:0] blank_cnt_nxt;
    logic [1:0]  mode_nxt;
    logic [7:0]  led_sel;
    logic [7:0]  led_nxt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SHOW;
        else        state <= state_nxt;
    end

    // Next-state logic. A press always lands in BLANK, including a press
    // that arrives during BLANK, so every mode change gets a full blank.
    always_comb begin
        state_nxt = state;
        case (state)
            SHOW:    if (press_evt) state_nxt = BLANK;
            BLANK:   if (press_evt)                    state_nxt = BLANK;
                     else if (blank_cnt == BLANK_LAST) state_nxt = SHOW;
            default: state_nxt = SHOW;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        mode_nxt = mode;
        if (press_evt)
            mode_nxt = (mode == MODE_LAST) ? 2'd0 : mode + 2'd1;

        blank_cnt_nxt = blank_cnt;
        if (press_evt)
            blank_cnt_nxt = 24'd0;
        else if (state == BLANK)
            blank_cnt_nxt = (blank_cnt == BLANK_LAST) ? 24'd0 : blank_cnt + 24'd1;

        // mode never exceeds NUM_MODES-1, so the unused inputs are never
        // selected.
        case (mode)
            2'd0:    led_sel = mode0_led;
            2'd1:    led_sel = mode1_led;
            2'd2:    led_sel = mode2_led;
            default: led_sel = mode3_led;
        endcase

        led_nxt = (state == BLANK) ? 8'h00 : led_sel;
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode      <= 2'd0;
            blank_cnt <= 24'd0;
            led_out   <= 8'h00;
            mode_chg  <= 1'b0;
        end else begin
            mode      <= mode_nxt;
            blank_cnt <= blank_cnt_nxt;
            led_out   <= led_nxt;
            mode_chg  <= press_evt;
        end
    end

endmodule

// File: doc/led_mode_selector.md
# led_mode_selector

Output stage of the heartbeat-light design. It sits directly downstream of the per-mode LED drivers, including the mode-2 driver. It consumes their 8-bit `led_out` patterns and debounces the single user push-button. Each press steps through the modes. A short all-off blanking interval is inserted on every mode change, and the selected pattern is driven to the board LEDs through a register.

## Interface
Parameters:
- `NUM_MODES`, default 4: number of active modes, legal range 2..4; mode index wraps from `NUM_MODES-1` to 0.
- `DEBOUNCE_CYC`, default 240000: consecutive stable cycles required to accept a key level (20 ms at 12 MHz); legal range 1..2^24-1.
- `BLANK_CYC`, default 600000: cycles of forced all-off output after a mode change (50 ms at 12 MHz); legal range 1..2^24-1.

Ports:
- `clk`, input, 1: system clock, 12 MHz. One clock domain only.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `key_n`, input, 1: raw push-button, active-low (0 = pressed), asynchronous to `clk`.
- `mode0_led`, input, 8: pattern from the mode-0 driver.
- `mode1_led`, input, 8: pattern from the mode-1 driver.
- `mode2_led`, input, 8: pattern from the mode-2 driver.
- `mode3_led`, input, 8: pattern from the mode-3 driver.
- `led_out`, output, 8: registered LED drive, 1 = LED on.
- `mode`, output, 2: current mode index, registered.
- `mode_chg`, output, 1: one-cycle pulse on each accepted press.

## Operation
- Synchronizer: two flops on `key_n`, giving `key_sync`. Both flops reset to 1.
- Debouncer:
  - Registered `key_state` (reset value 1) and a 24-bit counter `db_cnt` (reset value 0).
  - If `key_sync == key_state`: `db_cnt <= 0`.
  - Otherwise, if `db_cnt == DEBOUNCE_CYC-1`: `key_state <= key_sync` and `db_cnt <= 0`.
  - Otherwise: `db_cnt <= db_cnt+1`.
  - Any bounce back to the accepted level restarts the count.
- Press event: the clock edge at which `key_state` goes 1→0. A release (0→1) is debounced the same way but triggers no action.
- State machine with two states, SHOW and BLANK; reset state is SHOW.
  - SHOW: on a press event, `mode <= (mode==NUM_MODES-1) ? 0 : mode+1`, `blank_cnt <= 0`, go to BLANK.
  - BLANK: `blank_cnt` increments each cycle. When `blank_cnt == BLANK_CYC-1`, go to SHOW.
  - A press event in BLANK advances `mode` again (same wrap rule), restarts `blank_cnt` at 0, and stays in BLANK.
- Output register:
  - `led_out <= 8'h00` while the state is BLANK.
  - Otherwise `led_out <= modeN_led` selected by the current `mode`.
  - Inputs for indices ≥ `NUM_MODES` are never selected.
- `mode_chg` is registered high for exactly the cycle following each press event edge.
- Reset values: `led_out` = 8'h00, `mode` = 0, `mode_chg` = 0, state = SHOW, all counters = 0, `key_state` = 1.
  - Reset takes effect immediately and asynchronously at any point, including mid-blank or mid-debounce.
  - After reset release, the first edge loads `mode0_led` into `led_out`.

## Timing
- Key latency: a clean falling edge on `key_n` becomes a press event 2 + `DEBOUNCE_CYC` clock edges later (2 synchronizer edges plus `DEBOUNCE_CYC` edges of mismatch).
- Glitch rejection: a low pulse shorter than `DEBOUNCE_CYC` cycles, measured at `key_sync`, produces no event.
- Press at edge E:
  - `mode` and `mode_chg` are visible after E.
  - `led_out` reads 8'h00 from edge E+1 through edge E+`BLANK_CYC`.
  - The new mode's pattern appears at edge E+`BLANK_CYC`+1.
- Pattern path latency in SHOW: a change on `modeN_led` appears on `led_out` one edge later.
- Holding the key produces exactly one event per press; auto-repeat is never generated.

## Test plan
Bench parameters: `DEBOUNCE_CYC`=8, `BLANK_CYC`=5, `NUM_MODES`=4.
- Reset: assert `rst_n`=0 mid-operation with `mode1_led`=8'hA5. Required: `led_out`=8'h00 and `mode`=0 immediately. After release with `mode0_led`=8'h3C, `led_out`=8'h3C at the first edge.
- Clean press: drive `key_n` low for 20 cycles. Required: `mode` goes 0→1 exactly 10 edges after the fall, `mode_chg` high for 1 cycle, `led_out`=8'h00 for 5 cycles, then `led_out`=`mode1_led`.
- Bounce: drive `key_n` low for 5 cycles, high for 2, low for 7, then high. Required: no `mode_chg` and `mode` unchanged.
- Wrap: four clean presses separated by 30 cycles. Required: `mode` sequence 1,2,3,0, four `mode_chg` pulses.
- Press during blank: a second accepted press lands 2 cycles after the first. Required: `mode` advances twice, and `led_out` stays 8'h00 until 5 cycles after the second press.
- Pass-through: in SHOW with `mode`=0, toggle `mode0_led` between 8'h01 and 8'h80 every cycle. Required: `led_out` tracks the input with 1-cycle delay.
